// File: rtl/sr_latch_driver.sv
// sr_latch_driver: command sequencer sitting directly upstream of an SR latch.
// Takes commands over a valid/ready handshake. It drives the latch S/R levels,
// the async nP/nR forces and the gated latch clock LC. After a settle window it
// reads Q/Qbar back and reports completion with DONE/ERR/QS.
//
// Ports
//   C          system clock, rising edge
//   RST        synchronous reset, active-high
//   CMD        000 HOLD, 001 SET, 010 CLR, 011 PRESET, 100 FCLR, 101-111 illegal
//   CMD_VALID  CMD is valid
//   CMD_READY  idle, accepting CMD
//   Q, Qbar    latch read-back
//   S, R       latch set/reset levels
//   nP, nR     latch async preset/reset, active-low
//   LC         latch clock, 1 = transparent
//   DONE       one-cycle completion pulse
//   ERR        error status of the last completed command
//   QS         Q sampled at the last completing check
//
// Build option: define SR_DRV_RETRY_EN to re-run a failed legal command once
// before reporting. Without it, a failure is reported at the first check.
module sr_latch_driver #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       C,
  input  logic       RST,
  input  logic [2:0] CMD,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       Q,
  input  logic       Qbar,
  output logic       S,
  output logic       R,
  output logic       nP,
  output logic       nR,
  output logic       LC,
  output logic       DONE,
  output logic       ERR,
  output logic       QS
);

`ifdef SR_DRV_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_REJECT
  } state_e;

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'd0,
    CMD_SET    = 3'd1,
    CMD_CLR    = 3'd2,
    CMD_PRESET = 3'd3,
    CMD_FCLR   = 3'd4
  } cmd_e;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retry_q, retry_d;    // first check failed, second attempt pending
  logic             second_q, second_d;  // currently running the second attempt

  logic ready_q, ready_d;
  logic s_q, s_d;
  logic r_q, r_d;
  logic np_q, np_d;
  logic nr_q, nr_d;
  logic lc_q, lc_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic qs_q, qs_d;

  logic accept;
  logic cmd_legal;
  logic exp_q;
  logic latch_ok;
  logic final_check;
  cmd_e cmd_eff;

  assign accept    = CMD_VALID && ready_q;
  assign cmd_legal = (CMD <= 3'd4);

  // Outputs are registered from the next state, so the levels for SETUP must
  // come from the incoming CMD on the accepting edge.
  assign cmd_eff = (state_q == ST_IDLE) ? cmd_e'(CMD) : cmd_q;

  always_comb begin
    case (cmd_q)
      CMD_SET, CMD_PRESET: exp_q = 1'b1;
      CMD_CLR, CMD_FCLR:   exp_q = 1'b0;
      default:             exp_q = qs_q;
    endcase
  end

  // Complementary read-back that matches the expected level.
  assign latch_ok = (Q ^ Qbar) && (Q == exp_q);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    second_d = second_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          retry_d  = 1'b0;
          second_d = 1'b0;
          if (cmd_legal) begin
            cmd_d   = cmd_e'(CMD);
            state_d = ST_SETUP;
          end else begin
            state_d = ST_REJECT;
          end
        end
      end
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
          retry_d = RETRY && !latch_ok && !second_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (retry_q) begin
          state_d  = ST_SETUP;
          second_d = 1'b1;
          retry_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Q is sampled on the edge entering CHECK. A check that triggers a retry
  // leaves QS untouched, so a retried HOLD still compares against the old QS.
  assign final_check = (state_q == ST_SETTLE) && (state_d == ST_CHECK) && !retry_d;

  always_comb begin
    s_d     = 1'b0;
    r_d     = 1'b0;
    np_d    = 1'b1;
    nr_d    = 1'b1;
    lc_d    = 1'b0;
    ready_d = (state_d == ST_IDLE);
    done_d  = 1'b0;
    err_d   = err_q;
    qs_d    = qs_q;
    if (state_d inside {ST_SETUP, ST_PULSE, ST_SETTLE}) begin
      s_d  = (cmd_eff == CMD_SET);
      r_d  = (cmd_eff == CMD_CLR);
      np_d = (cmd_eff != CMD_PRESET);
      nr_d = (cmd_eff != CMD_FCLR);
      lc_d = (state_d == ST_PULSE) && (cmd_eff inside {CMD_HOLD, CMD_SET, CMD_CLR});
    end
    if (final_check) begin
      done_d = 1'b1;
      err_d  = !latch_ok;
      qs_d   = Q;
    end else if (state_d == ST_REJECT) begin
      done_d = 1'b1;
      err_d  = 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_HOLD;
      cnt_q    <= '0;
      retry_q  <= 1'b0;
      second_q <= 1'b0;
      ready_q  <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      np_q     <= 1'b1;
      nr_q     <= 1'b1;
      lc_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      qs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      second_q <= second_d;
      ready_q  <= ready_d;
      s_q      <= s_d;
      r_q      <= r_d;
      np_q     <= np_d;
      nr_q     <= nr_d;
      lc_q     <= lc_d;
      done_q   <= done_d;
      err_q    <= err_d;
      qs_q     <= qs_d;
    end
  end

  assign CMD_READY = ready_q;
  assign S         = s_q;
  assign R         = r_q;
  assign nP        = np_q;
  assign nR        = nr_q;
  assign LC        = lc_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign QS        = qs_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver: behavioural latch, offset-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sr_latch_driver;

`ifdef SR_DRV_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int SC = 2;
  localparam int L  = 3 + SC;   // accept edge to completion, in cycles

  logic       C = 1'b0;
  logic       RST;
  logic [2:0] CMD;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       Q, Qbar;
  logic       S, R, nP, nR, LC, DONE, ERR, QS;

  int vectors = 0;
  int miscompares = 0;

  sr_latch_driver #(.SETTLE_CYC(SC), .CNT_W(4)) dut (
    .C(C), .RST(RST), .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .Q(Q), .Qbar(Qbar), .S(S), .R(R), .nP(nP), .nR(nR), .LC(LC),
    .DONE(DONE), .ERR(ERR), .QS(QS)
  );

  always #5 C = ~C;

  // latch: 0 = healthy, 1 = stuck at Q=1/Qbar=0, 2 = random read-back
  int   lmode = 0;
  logic lq = 1'b0;

  initial begin
    Q = 1'b0;
    Qbar = 1'b1;
    forever begin
      @(negedge C);
      if (nP === 1'b0) lq = 1'b1;
      else if (nR === 1'b0) lq = 1'b0;
      else if (LC === 1'b1) begin
        if (S && !R) lq = 1'b1;
        else if (R && !S) lq = 1'b0;
      end
      case (lmode)
        0:       begin Q = lq;   Qbar = ~lq;  end
        1:       begin Q = 1'b1; Qbar = 1'b0; end
        default: begin Q = 1'($urandom); Qbar = 1'($urandom); end
      endcase
    end
  end

  // Reference model: command timeline measured as offset from the accept edge.
  bit         started = 0;
  bit         m_rst = 1, m_busy = 0, m_legal = 0, m_retried = 0;
  int         m_off = 0, m_end = 0;
  logic [2:0] m_cmd = '0;
  logic       m_qs = 1'b0, m_err = 1'b0;
  logic [8:0] exp_vec = '0;  // {READY,S,R,nP,nR,LC,DONE,ERR,QS}

  function automatic logic [8:0] expected();
    int o;
    if (m_rst) return 9'b000110000;
    if (!m_busy) return {1'b1, 4'b0011, 2'b00, m_err, m_qs};
    if (!m_legal) return {1'b0, 4'b0011, 2'b01, m_err, m_qs};
    o = ((m_off - 1) % L) + 1;
    if (o < L)
      return {1'b0, m_cmd == 3'd1, m_cmd == 3'd2, m_cmd != 3'd3, m_cmd != 3'd4,
              (o == 2) && (m_cmd <= 3'd2), 1'b0, m_err, m_qs};
    return {1'b0, 4'b0011, 1'b0, m_off == m_end, m_err, m_qs};
  endfunction

  initial begin
    bit   prev_ready, ok;
    logic want;
    forever begin
      @(posedge C);
      prev_ready = exp_vec[8];
      if (RST) begin
        started = 1;
        m_rst = 1; m_busy = 0; m_qs = 1'b0; m_err = 1'b0;
      end else begin
        m_rst = 0;
        if (m_busy) begin
          if (m_off == m_end) m_busy = 0;
          else begin
            m_off++;
            if (m_off == m_end) begin
              want = (m_cmd == 3'd1 || m_cmd == 3'd3) ? 1'b1 :
                     (m_cmd == 3'd0) ? m_qs : 1'b0;
              ok = (Q !== Qbar) && (Q === want);
              if (!ok && RETRY && !m_retried) begin
                m_retried = 1;
                m_end = m_end + L;
              end else begin
                m_qs = Q;
                m_err = !ok;
              end
            end
          end
        end else if (prev_ready && CMD_VALID) begin
          m_busy = 1; m_off = 1; m_cmd = CMD; m_retried = 0;
          m_legal = (CMD <= 3'd4);
          if (m_legal) m_end = L;
          else begin m_end = 1; m_err = 1'b1; end
        end
      end
      exp_vec = expected();
    end
  end

  // Cycle-by-cycle compare against the model, plus latch-safety invariants.
  initial begin
    logic [8:0] act;
    forever begin
      @(negedge C);
      if (started) begin
        act = {CMD_READY, S, R, nP, nR, LC, DONE, ERR, QS};
        vectors++;
        if (act !== exp_vec) begin
          miscompares++;
          $display("FAIL outputs t=%0t got %b want %b (RDY,S,R,nP,nR,LC,DONE,ERR,QS)",
                   $time, act, exp_vec);
        end
        vectors++;
        if ((!nP && !nR) || (S && R) || (LC && (!nP || !nR))) begin
          miscompares++;
          $display("FAIL invariant t=%0t got S=%b R=%b nP=%b nR=%b LC=%b want no conflict",
                   $time, S, R, nP, nR, LC);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!exp_vec[8]) begin
      @(posedge C); #1;
      waited++;
      if (waited > 64) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout t=%0t got busy want idle", $time);
        return;
      end
    end
  endtask

  // Issue one command and pin DONE/LC timing and the reported QS/ERR literally.
  task automatic run_cmd(input logic [2:0] c, input int done_off, input logic e_qs,
                         input logic e_err, input int lc_off);
    wait_ready();
    CMD = c;
    CMD_VALID = 1'b1;
    @(posedge C); #1;
    for (int o = 1; o <= done_off; o++) begin
      if (o < done_off) begin
        CMD_VALID = 1'($urandom);
        CMD = 3'($urandom);
      end else begin
        CMD_VALID = 1'b0;
      end
      @(negedge C);
      chk("done_timing", DONE, o == done_off);
      chk("lc_timing", LC, o == lc_off);
      if (o == done_off) begin
        chk("qs", QS, e_qs);
        chk("err", ERR, e_err);
      end
      @(posedge C); #1;
    end
  endtask

  initial begin
    RST = 1'b1;
    CMD_VALID = 1'b0;
    CMD = '0;
    repeat (2) @(posedge C);
    @(negedge C);
    chk("reset_ready", CMD_READY, 1'b0);
    chk("reset_np", nP, 1'b1);
    @(posedge C); #1;
    RST = 1'b0;
    @(posedge C); #1;
    chk("ready_after_reset", CMD_READY, 1'b1);

    run_cmd(3'b001, 5, 1'b1, 1'b0, 2);  // SET
    run_cmd(3'b000, 5, 1'b1, 1'b0, 2);  // HOLD keeps 1
    run_cmd(3'b011, 5, 1'b1, 1'b0, 0);  // PRESET
    run_cmd(3'b100, 5, 1'b0, 1'b0, 0);  // FCLR
    lmode = 1;
    run_cmd(3'b010, RETRY ? 10 : 5, 1'b1, 1'b1, 2);  // CLR against stuck latch
    lmode = 0;
    run_cmd(3'b111, 1, 1'b1, 1'b1, 0);  // illegal, QS unchanged

    // Abort a SET during its settle window.
    wait_ready();
    CMD = 3'b001;
    CMD_VALID = 1'b1;
    @(posedge C); #1;
    CMD_VALID = 1'b0;
    @(posedge C); #1;
    @(posedge C); #1;
    RST = 1'b1;
    @(posedge C); #1;
    RST = 1'b0;
    @(negedge C);
    chk("abort_done", DONE, 1'b0);
    chk("abort_s", S, 1'b0);
    chk("abort_ready", CMD_READY, 1'b0);
    run_cmd(3'b010, 5, 1'b0, 1'b0, 2);  // CLR after abort

    // Randomized traffic; the model tracks everything including resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 40 == 0) begin
        case ($urandom % 6)
          4:       lmode = 1;
          5:       lmode = 2;
          default: lmode = 0;
        endcase
      end
      RST = ($urandom % 300) == 0;
      CMD_VALID = ($urandom % 3) == 0;
      CMD = ($urandom % 5 == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
      @(posedge C); #1;
    end
    RST = 1'b0;
    CMD_VALID = 1'b0;
    lmode = 0;
    repeat (30) @(posedge C);
    @(negedge C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
